// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// per-stage NOP control words and control-field widths.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_FULL      = 2'd1;
    localparam logic [1:0] ST_SKID_FULL = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY     = ST_EMPTY,
        S_FULL      = ST_FULL,
        S_SKID_FULL = ST_SKID_FULL
    } state_t;

    // Control-word field widths shared by all stages
    localparam int CTRL_W_DEF    = 32;
    localparam int ALU_OP_W      = 5;
    localparam int MEM_OP_W      = 3;
    localparam int WB_SEL_W      = 2;
    localparam int RD_ADDR_W     = 5;

    // A NOP is "no register write, no memory access"; encodings differ per stage
    localparam logic [CTRL_W_DEF-1:0] IF_ID_NOP  = 32'h0000_0013;
    localparam logic [CTRL_W_DEF-1:0] ID_EX_NOP  = 32'h0000_00A5;
    localparam logic [CTRL_W_DEF-1:0] EX_MEM_NOP = 32'h0000_0000;
    localparam logic [CTRL_W_DEF-1:0] MEM_WB_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// Single holding slot (valid + control + payload) used as the skid entry
// of a pipeline stage; clear wins over load.
module pipe_skid_slot #(
    parameter int                 DATA_W   = 256,
    parameter int                 CTRL_W   = 32,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] next_ctrl,
    input  logic [DATA_W-1:0] next_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= next_ctrl;
            data  <= next_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid
// entry, flush to NOP and a saturating bubble counter.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   S_EMPTY     | no valid entry; main holds CTRL_NOP / zero payload
//   S_FULL      | main holds a valid entry, skid empty
//   S_SKID_FULL | main and skid both valid; upstream is held off
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 256,
    parameter int                 CTRL_W   = 32,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_nop;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != S_EMPTY);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_slot #(
                .DATA_W   (DATA_W),
                .CTRL_W   (CTRL_W),
                .CTRL_NOP (CTRL_NOP)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (skid_load),
                .clear     (skid_clr),
                .next_ctrl (in_ctrl),
                .next_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
            // Registered ready: no path from out_ready back to in_ready
            assign in_ready = !skid_valid;
        end else begin : g_no_skid
            logic unused_skid;
            assign unused_skid = skid_load | skid_clr | skid_valid;
            assign skid_valid  = 1'b0;
            assign skid_ctrl   = CTRL_NOP;
            assign skid_data   = '0;
            assign in_ready    = out_ready | !out_valid;
        end
    endgenerate

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_nop       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
            main_nop  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_valid) begin
                        main_load = 1'b1;
                        state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_load = 1'b1;
                        end else begin
                            main_nop  = 1'b1;
                            state_nxt = S_EMPTY;
                        end
                    end else if (in_valid && SKID != 0) begin
                        skid_load = 1'b1;
                        state_nxt = S_SKID_FULL;
                    end
                end
                S_SKID_FULL: begin
                    if (out_ready) begin
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = S_FULL;
                    end
                end
                default: begin
                    main_nop  = 1'b1;
                    skid_clr  = 1'b1;
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            main_ctrl <= CTRL_NOP;
            main_data <= '0;
        end else begin
            state <= state_nxt;
            if (main_nop) begin
                main_ctrl <= CTRL_NOP;
                main_data <= '0;
            end else if (main_from_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end else if (main_load) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!out_valid && bubble_cnt != {CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a control word and a data word with a valid/ready handshake, an optional skid slot, flush, and a registered NOP bubble pattern. A saturating bubble counter supports pipeline performance monitoring.

Parameters:
DATA_W, 256, width of the datapath payload (for example pc, rs1Data, rs2Data and imm64 concatenated).
CTRL_W, 32, width of the packed control word.
CTRL_NOP, {CTRL_W{1'b0}}, control value driven whenever the stage holds no valid instruction; overridden per stage.
SKID, 1, 1 = two-entry (main plus skid) with fully registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 32, width of bubble_cnt.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
flush  in  1  discard all held and incoming entries.
in_valid  in  1  upstream has an entry.
in_ready  out  1  stage accepts an entry this cycle.
in_ctrl  in  CTRL_W  upstream control word.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage presents a valid entry.
out_ready  in  1  downstream consumes the entry this cycle.
out_ctrl  out  CTRL_W  registered control; equals CTRL_NOP when out_valid=0.
out_data  out  DATA_W  registered payload; zero when out_valid=0.
cnt_clr  in  1  synchronous clear of bubble_cnt.
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

Behaviour:
- Reset (rst_n=0 at an edge): state EMPTY, out_valid=0, out_ctrl=CTRL_NOP, out_data=0, skid cleared, bubble_cnt=0. Reset takes precedence over every other input.
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: an entry accepted into EMPTY appears on out_* the next cycle.
- While out_valid=1 & out_ready=0, out_ctrl and out_data hold stable.
- States (SKID=1):
  - EMPTY: in_ready=1. On in_valid, load main and go to FULL.
  - FULL: in_ready=1.
    - out_ready & in_valid: reload main, stay in FULL.
    - out_ready & !in_valid: load CTRL_NOP/0 into main, go to EMPTY.
    - !out_ready & in_valid: load skid, go to SKID_FULL.
  - SKID_FULL: in_ready=0. On out_ready, main<=skid, clear skid, go to FULL.
- in_ready (SKID=1) is a pure register output (=!skid_valid). No combinational path exists from out_ready to in_ready.
- SKID=0: there is no SKID_FULL state. in_ready = out_ready | !out_valid (combinational). In FULL with !out_ready, the stage stalls.
- Flush (rst_n=1, flush=1): next state EMPTY, main loaded with CTRL_NOP/0, skid cleared. Any same-cycle input transfer is discarded. An output transfer in the flush cycle still counts as consumed. in_ready is unaffected by flush in the flush cycle.
- Bubble counter:
  - Each cycle with out_valid=0 and !rst, bubble_cnt increments by 1.
  - It saturates at all-ones and does not wrap.
  - cnt_clr sets it to 0 and overrides the increment in the same cycle.
  - flush does not clear it.
- No entry is ever duplicated or dropped except by flush.
- Accepted entries leave in order.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID_FULL=2'd2;
  - per-stage CTRL_NOP constants (ID_EX_NOP etc.);
  - control-field width constants.
- One sub-module, pipe_skid_slot: a single valid+ctrl+data holding register with load/clear, instantiated under generate when SKID=1.
- Counter logic stays inline.

Test Plan:
1. Reset behaviour, with CTRL_NOP=32'h0000_00A5. Hold rst_n=0 for 2 cycles, then release with in_valid=0. Required: out_valid=0, out_ctrl=32'h0000_00A5, out_data=0, and bubble_cnt counts 1,2,3 on successive cycles.
2. Streaming. Drive in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1. Required: out_data=1,2,3,4 one cycle later, out_valid continuously 1, in_ready always 1.
3. Backpressure (SKID=1). Send data=10 then 11; drop out_ready for 3 cycles while in_valid=1 offering 12. Required: out_data holds 10, the skid holds 11, in_ready=0 the cycle after the skid fills, and 12 is not accepted. On out_ready=1 the outputs are 10, 11, 12 in order with no loss.
4. Flush in SKID_FULL. Flush with in_valid=1 (data=20). Required: next cycle out_valid=0, out_ctrl=CTRL_NOP, entry 20 is discarded, and the state returns to EMPTY.
5. SKID=0 build. out_ready=0 while full. Required: in_ready=0 in the same cycle (combinational), and out_data is unchanged.
6. Counter edge cases (CNT_W=4). Hold 20 empty cycles. Required: bubble_cnt saturates at 4'hF. Then cnt_clr=1 in a cycle with out_valid=0. Required: bubble_cnt=0 next cycle, not 1.
